axi_lite_pl_splitter: RTL and testbench

Parametrised AXI4-Lite fan-out between the PS crossbar slave port and NUM_PORTS PL register banks: one AD9361 core instance per port, with two ports for FMCOMMS5. It decodes a port index from the address, forwards one transaction at a time, and returns DECERR for unmapped indices. It also returns SLVERR, and marks the port faulted, when a downstream bank fails to respond within a timeout.

---
 rtl/axi_lite_pl_splitter.sv | 332 +++++++++++++++++++++++++++++++++
 tb/tb_axi_lite_pl_splitter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_pl_splitter.sv
// AXI4-Lite 1:NUM_PORTS splitter; one transaction in flight, DECERR on
// unmapped windows, optional timeout/fault (AXI_LITE_SPLIT_TIMEOUT_EN).
// Ports: s_axi_* crossbar slave side, m_axi_* per-port master vectors,
// port_fault sticky per-port timeout flags.
module axi_lite_pl_splitter #(
  parameter int NUM_PORTS      = 2,
  parameter int SLICE_BITS     = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      axi_aclk,
  input  logic                      axi_aresetn,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [31:0]               s_axi_awaddr,
  input  logic [2:0]                s_axi_awprot,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  input  logic [31:0]               s_axi_wdata,
  input  logic [3:0]                s_axi_wstrb,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  output logic [1:0]                s_axi_bresp,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  input  logic [31:0]               s_axi_araddr,
  input  logic [2:0]                s_axi_arprot,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [31:0]               s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic [NUM_PORTS-1:0]      m_axi_awvalid,
  input  logic [NUM_PORTS-1:0]      m_axi_awready,
  output logic [32*NUM_PORTS-1:0]   m_axi_awaddr,
  output logic [3*NUM_PORTS-1:0]    m_axi_awprot,
  output logic [NUM_PORTS-1:0]      m_axi_wvalid,
  input  logic [NUM_PORTS-1:0]      m_axi_wready,
  output logic [32*NUM_PORTS-1:0]   m_axi_wdata,
  output logic [4*NUM_PORTS-1:0]    m_axi_wstrb,
  input  logic [NUM_PORTS-1:0]      m_axi_bvalid,
  output logic [NUM_PORTS-1:0]      m_axi_bready,
  input  logic [2*NUM_PORTS-1:0]    m_axi_bresp,
  output logic [NUM_PORTS-1:0]      m_axi_arvalid,
  input  logic [NUM_PORTS-1:0]      m_axi_arready,
  output logic [32*NUM_PORTS-1:0]   m_axi_araddr,
  output logic [3*NUM_PORTS-1:0]    m_axi_arprot,
  input  logic [NUM_PORTS-1:0]      m_axi_rvalid,
  output logic [NUM_PORTS-1:0]      m_axi_rready,
  input  logic [32*NUM_PORTS-1:0]   m_axi_rdata,
  input  logic [2*NUM_PORTS-1:0]    m_axi_rresp,
  output logic [NUM_PORTS-1:0]      port_fault
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int NPAD  = 1 << IDX_W;

  typedef enum logic [2:0] {
    IDLE, WR_FWD, WR_B, WR_RSP, RD_FWD, RD_R, RD_RSP
  } state_e;

  state_e state_q, state_d;

  logic awrdy_q, awrdy_d, arrdy_q, arrdy_d;
  logic last_wr_q, last_wr_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [3:0]  strb_q, strb_d;
  logic [2:0]  prot_q, prot_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NUM_PORTS-1:0] awv_q, awv_d, wv_q, wv_d, bry_q, bry_d;
  logic [NUM_PORTS-1:0] arv_q, arv_d, rry_q, rry_d;
  logic bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;

  logic [IDX_W-1:0] aw_idx, ar_idx;
  logic aw_unmap, ar_unmap;
  logic aw_left, w_left, ar_left;
  logic [NPAD-1:0] fault_ext;

  // Any set bit above the index field is unmapped, not just idx overflow.
  assign aw_idx   = s_axi_awaddr[SLICE_BITS +: IDX_W];
  assign ar_idx   = s_axi_araddr[SLICE_BITS +: IDX_W];
  assign aw_unmap = (s_axi_awaddr >> SLICE_BITS) >= 32'(NUM_PORTS);
  assign ar_unmap = (s_axi_araddr >> SLICE_BITS) >= 32'(NUM_PORTS);

  assign aw_left = awv_q[idx_q] & ~m_axi_awready[idx_q];
  assign w_left  = wv_q[idx_q] & ~m_axi_wready[idx_q];
  assign ar_left = arv_q[idx_q] & ~m_axi_arready[idx_q];

`ifdef AXI_LITE_SPLIT_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [NUM_PORTS-1:0] fault_q, fault_d;
  logic done;

  assign done = (state_q == WR_B && m_axi_bvalid[idx_q] && bry_q[idx_q]) ||
                (state_q == RD_R && m_axi_rvalid[idx_q] && rry_q[idx_q]);
  assign fault_ext  = NPAD'(fault_q);
  assign port_fault = fault_q;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      cnt_q   <= '0;
      fault_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
`else
  assign fault_ext  = '0;
  assign port_fault = '0;
`endif

  always_comb begin
    state_d   = state_q;
    awrdy_d   = 1'b0;
    arrdy_d   = 1'b0;
    last_wr_d = last_wr_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    prot_d    = prot_q;
    idx_d     = idx_q;
    awv_d     = awv_q;
    wv_d      = wv_q;
    bry_d     = bry_q;
    arv_d     = arv_q;
    rry_d     = rry_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
`ifdef AXI_LITE_SPLIT_TIMEOUT_EN
    cnt_d     = cnt_q;
    fault_d   = fault_q;
`endif
    unique case (state_q)
      IDLE: begin
        // Readies are registered: grant one cycle, complete the next.
        if (awrdy_q) begin
          if (s_axi_awvalid && s_axi_wvalid) begin
            addr_d    = s_axi_awaddr;
            data_d    = s_axi_wdata;
            strb_d    = s_axi_wstrb;
            prot_d    = s_axi_awprot;
            idx_d     = aw_idx;
            last_wr_d = 1'b1;
`ifdef AXI_LITE_SPLIT_TIMEOUT_EN
            cnt_d     = '0;
`endif
            if (aw_unmap) begin
              bvalid_d = 1'b1;
              bresp_d  = 2'b11;
              state_d  = WR_RSP;
            end else if (fault_ext[aw_idx]) begin
              bvalid_d = 1'b1;
              bresp_d  = 2'b10;
              state_d  = WR_RSP;
            end else begin
              awv_d[aw_idx] = 1'b1;
              wv_d[aw_idx]  = 1'b1;
              state_d       = WR_FWD;
            end
          end
        end else if (arrdy_q) begin
          if (s_axi_arvalid) begin
            addr_d    = s_axi_araddr;
            prot_d    = s_axi_arprot;
            idx_d     = ar_idx;
            last_wr_d = 1'b0;
`ifdef AXI_LITE_SPLIT_TIMEOUT_EN
            cnt_d     = '0;
`endif
            if (ar_unmap) begin
              rvalid_d = 1'b1;
              rresp_d  = 2'b11;
              rdata_d  = '0;
              state_d  = RD_RSP;
            end else if (fault_ext[ar_idx]) begin
              rvalid_d = 1'b1;
              rresp_d  = 2'b10;
              rdata_d  = '0;
              state_d  = RD_RSP;
            end else begin
              arv_d[ar_idx] = 1'b1;
              state_d       = RD_FWD;
            end
          end
        end else if (s_axi_awvalid && s_axi_wvalid &&
                     (!s_axi_arvalid || !last_wr_q)) begin
          awrdy_d = 1'b1;
        end else if (s_axi_arvalid) begin
          arrdy_d = 1'b1;
        end
      end
      WR_FWD: begin
        awv_d[idx_q] = aw_left;
        wv_d[idx_q]  = w_left;
        if (!aw_left && !w_left) begin
          bry_d[idx_q] = 1'b1;
          state_d      = WR_B;
        end
      end
      WR_B: begin
        if (m_axi_bvalid[idx_q] && bry_q[idx_q]) begin
          bry_d[idx_q] = 1'b0;
          bvalid_d     = 1'b1;
          bresp_d      = m_axi_bresp[2*idx_q +: 2];
          state_d      = WR_RSP;
        end
      end
      WR_RSP: begin
        if (s_axi_bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      RD_FWD: begin
        arv_d[idx_q] = ar_left;
        if (!ar_left) begin
          rry_d[idx_q] = 1'b1;
          state_d      = RD_R;
        end
      end
      RD_R: begin
        if (m_axi_rvalid[idx_q] && rry_q[idx_q]) begin
          rry_d[idx_q] = 1'b0;
          rvalid_d     = 1'b1;
          rresp_d      = m_axi_rresp[2*idx_q +: 2];
          rdata_d      = m_axi_rdata[32*idx_q +: 32];
          state_d      = RD_RSP;
        end
      end
      RD_RSP: begin
        if (s_axi_rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef AXI_LITE_SPLIT_TIMEOUT_EN
    // Expiry overrides forward progress but never a completing handshake.
    if (state_q inside {WR_FWD, WR_B, RD_FWD, RD_R}) begin
      cnt_d = cnt_q + 16'd1;
      if (cnt_q == 16'(TIMEOUT_CYCLES - 1) && !done) begin
        awv_d          = '0;
        wv_d           = '0;
        bry_d          = '0;
        arv_d          = '0;
        rry_d          = '0;
        fault_d[idx_q] = 1'b1;
        if (state_q inside {WR_FWD, WR_B}) begin
          bvalid_d = 1'b1;
          bresp_d  = 2'b10;
          state_d  = WR_RSP;
        end else begin
          rvalid_d = 1'b1;
          rresp_d  = 2'b10;
          rdata_d  = '0;
          state_d  = RD_RSP;
        end
      end
    end
`endif
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q   <= IDLE;
      awrdy_q   <= 1'b0;
      arrdy_q   <= 1'b0;
      last_wr_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      prot_q    <= '0;
      idx_q     <= '0;
      awv_q     <= '0;
      wv_q      <= '0;
      bry_q     <= '0;
      arv_q     <= '0;
      rry_q     <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      awrdy_q   <= awrdy_d;
      arrdy_q   <= arrdy_d;
      last_wr_q <= last_wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      prot_q    <= prot_d;
      idx_q     <= idx_d;
      awv_q     <= awv_d;
      wv_q      <= wv_d;
      bry_q     <= bry_d;
      arv_q     <= arv_d;
      rry_q     <= rry_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_axi_awready = awrdy_q;
  assign s_axi_wready  = awrdy_q;
  assign s_axi_arready = arrdy_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign m_axi_awvalid = awv_q;
  assign m_axi_wvalid  = wv_q;
  assign m_axi_bready  = bry_q;
  assign m_axi_arvalid = arv_q;
  assign m_axi_rready  = rry_q;
  assign m_axi_awaddr  = {NUM_PORTS{addr_q}};
  assign m_axi_araddr  = {NUM_PORTS{addr_q}};
  assign m_axi_wdata   = {NUM_PORTS{data_q}};
  assign m_axi_wstrb   = {NUM_PORTS{strb_q}};
  assign m_axi_awprot  = {NUM_PORTS{prot_q}};
  assign m_axi_arprot  = {NUM_PORTS{prot_q}};

endmodule

// File: tb/tb_axi_lite_pl_splitter.sv
// Directed bench for axi_lite_pl_splitter with two modelled PL banks.
// Expected responses are queued at issue and popped on s_axi B/R.
module tb_axi_lite_pl_splitter;

  localparam int NP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s_axi_awvalid = 0, s_axi_awready;
  logic [31:0] s_axi_awaddr = 0;
  logic [2:0]  s_axi_awprot = 0;
  logic        s_axi_wvalid = 0, s_axi_wready;
  logic [31:0] s_axi_wdata = 0;
  logic [3:0]  s_axi_wstrb = 0;
  logic        s_axi_bvalid, s_axi_bready = 1;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid = 0, s_axi_arready;
  logic [31:0] s_axi_araddr = 0;
  logic [2:0]  s_axi_arprot = 0;
  logic        s_axi_rvalid, s_axi_rready = 1;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;

  logic [NP-1:0]    m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [NP-1:0]    m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic [NP-1:0]    m_axi_rvalid, m_axi_rready, port_fault;
  logic [32*NP-1:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
  logic [4*NP-1:0]  m_axi_wstrb;
  logic [3*NP-1:0]  m_axi_awprot, m_axi_arprot;
  logic [2*NP-1:0]  m_axi_bresp, m_axi_rresp;

  axi_lite_pl_splitter #(
    .NUM_PORTS(NP), .SLICE_BITS(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_bresp(m_axi_bresp),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .port_fault(port_fault)
  );

  // Downstream bank models
  logic [NP-1:0] rdy_en = '1, rsp_en = '1;
  logic [1:0]    rsp_val [NP] = '{2'b00, 2'b00};
  logic [31:0]   rd_val [NP] = '{32'h0, 32'h0};
  logic [NP-1:0] aw_got, w_got, ar_pend, sl_bvalid, sl_rvalid;
  logic [2*NP-1:0]  sl_bresp, sl_rresp;
  logic [32*NP-1:0] sl_rdata;

  assign m_axi_awready = rdy_en;
  assign m_axi_wready  = rdy_en;
  assign m_axi_arready = rdy_en;
  assign m_axi_bvalid  = sl_bvalid;
  assign m_axi_rvalid  = sl_rvalid;
  assign m_axi_bresp   = sl_bresp;
  assign m_axi_rresp   = sl_rresp;
  assign m_axi_rdata   = sl_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_got <= '0; w_got <= '0; ar_pend <= '0;
      sl_bvalid <= '0; sl_rvalid <= '0;
      sl_bresp <= '0; sl_rresp <= '0; sl_rdata <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (m_axi_awvalid[p] && m_axi_awready[p]) aw_got[p] <= 1'b1;
        if (m_axi_wvalid[p] && m_axi_wready[p]) w_got[p] <= 1'b1;
        if (aw_got[p] && w_got[p] && !sl_bvalid[p] && rsp_en[p]) begin
          sl_bvalid[p] <= 1'b1;
          sl_bresp[2*p +: 2] <= rsp_val[p];
          aw_got[p] <= 1'b0;
          w_got[p] <= 1'b0;
        end
        if (sl_bvalid[p] && m_axi_bready[p]) sl_bvalid[p] <= 1'b0;
        if (m_axi_arvalid[p] && m_axi_arready[p]) ar_pend[p] <= 1'b1;
        if (ar_pend[p] && !sl_rvalid[p] && rsp_en[p]) begin
          sl_rvalid[p] <= 1'b1;
          sl_rresp[2*p +: 2] <= rsp_val[p];
          sl_rdata[32*p +: 32] <= rd_val[p];
          ar_pend[p] <= 1'b0;
        end
        if (sl_rvalid[p] && m_axi_rready[p]) sl_rvalid[p] <= 1'b0;
      end
    end
  end

  // Cycle counter and per-port activity monitor
  int cyc = 0;
  int act_cnt [NP] = '{0, 0};
  int aw_hs_cyc [NP] = '{0, 0};
  int b_hs_cyc [NP] = '{0, 0};
  int r_hs_cyc [NP] = '{0, 0};
  logic [31:0] last_awaddr [NP] = '{32'h0, 32'h0};
  logic [31:0] last_wdata [NP] = '{32'h0, 32'h0};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int p = 0; p < NP; p++) begin
      if (m_axi_awvalid[p] || m_axi_wvalid[p] || m_axi_arvalid[p] ||
          m_axi_bready[p] || m_axi_rready[p])
        act_cnt[p] <= act_cnt[p] + 1;
      if (m_axi_awvalid[p] && m_axi_awready[p]) begin
        aw_hs_cyc[p] <= cyc;
        last_awaddr[p] <= m_axi_awaddr[32*p +: 32];
      end
      if (m_axi_wvalid[p] && m_axi_wready[p])
        last_wdata[p] <= m_axi_wdata[32*p +: 32];
      if (m_axi_bvalid[p] && m_axi_bready[p]) b_hs_cyc[p] <= cyc;
      if (m_axi_rvalid[p] && m_axi_rready[p]) r_hs_cyc[p] <= cyc;
    end
  end

  typedef struct {
    bit          wr;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb [$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_xact(input logic [31:0] a, input logic [31:0] d,
                         output int acc, output int rsp);
    exp_t e;
    bit ok;
    acc = -1;
    rsp = -1;
    s_axi_awaddr = a;
    s_axi_wdata = d;
    s_axi_wstrb = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_axi_awready && s_axi_wready) begin ok = 1; break; end
    end
    check("wr_accept", 64'(ok), 64'd1);
    acc = cyc;
    @(posedge clk);
    #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_axi_bvalid) begin ok = 1; break; end
    end
    check("wr_resp_seen", 64'(ok), 64'd1);
    rsp = cyc;
    if (ok) begin
      check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("order_kind_wr", 64'd1, 64'(e.wr));
        check("bresp", 64'(s_axi_bresp), 64'(e.resp));
      end
    end
  endtask

  task automatic rd_xact(input logic [31:0] a, output int acc, output int rsp);
    exp_t e;
    bit ok;
    acc = -1;
    rsp = -1;
    s_axi_araddr = a;
    s_axi_arvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_axi_arready) begin ok = 1; break; end
    end
    check("rd_accept", 64'(ok), 64'd1);
    acc = cyc;
    @(posedge clk);
    #1;
    s_axi_arvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_axi_rvalid) begin ok = 1; break; end
    end
    check("rd_resp_seen", 64'(ok), 64'd1);
    rsp = cyc;
    if (ok) begin
      check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("order_kind_rd", 64'd0, 64'(e.wr));
        check("rresp", 64'(s_axi_rresp), 64'(e.resp));
        check("rdata", 64'(s_axi_rdata), 64'(e.rdata));
      end
    end
  endtask

  initial begin
    int acc, rsp, acc2, rsp2, a0, a1;
    bit ok;

    repeat (3) @(negedge clk);
    check("rst_s_ready", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd0);
    check("rst_s_valid", 64'({s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp}), 64'd0);
    check("rst_rdata", 64'(s_axi_rdata), 64'd0);
    check("rst_m_vr", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                           m_axi_arvalid, m_axi_rready}), 64'd0);
    check("rst_m_addr", {m_axi_awaddr[31:0], m_axi_wdata[63:32]}, 64'd0);
    check("rst_m_strb_prot", 64'({m_axi_wstrb, m_axi_awprot, m_axi_arprot}), 64'd0);
    check("rst_fault", 64'(port_fault), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write to port 1
    a0 = act_cnt[0];
    sb.push_back('{1'b1, 2'b00, 32'h0});
    wr_xact(32'h0001_0004, 32'hDEADBEEF, acc, rsp);
    check("w1_port0_idle", 64'(act_cnt[0] - a0), 64'd0);
    check("w1_aw_lat", 64'(aw_hs_cyc[1]), 64'(acc + 1));
    check("w1_awaddr", 64'(last_awaddr[1]), 64'h0001_0004);
    check("w1_wdata", 64'(last_wdata[1]), 64'hDEAD_BEEF);
    check("w1_b_lat", 64'(rsp), 64'(b_hs_cyc[1] + 1));

    // Read from port 0
    rd_val[0] = 32'h1234_5678;
    a1 = act_cnt[1];
    sb.push_back('{1'b0, 2'b00, 32'h1234_5678});
    rd_xact(32'h0000_0010, acc, rsp);
    check("r0_port1_idle", 64'(act_cnt[1] - a1), 64'd0);
    check("r0_r_lat", 64'(rsp), 64'(r_hs_cyc[0] + 1));

    // Downstream SLVERR is passed through
    rsp_val[1] = 2'b10;
    sb.push_back('{1'b1, 2'b10, 32'h0});
    wr_xact(32'h0001_0000, 32'h0000_0001, acc, rsp);
    rsp_val[1] = 2'b00;

    // Unmapped write and read
    a0 = act_cnt[0];
    a1 = act_cnt[1];
    sb.push_back('{1'b1, 2'b11, 32'h0});
    wr_xact(32'h0002_0000, 32'h5555_AAAA, acc, rsp);
    check("decw_lat", 64'(rsp), 64'(acc + 1));
    check("decw_no_act", 64'(act_cnt[0] - a0 + act_cnt[1] - a1), 64'd0);
    rd_val[1] = 32'hFFFF_FFFF;
    sb.push_back('{1'b0, 2'b11, 32'h0});
    rd_xact(32'hFFFF_0000, acc, rsp);
    check("decr_lat", 64'(rsp), 64'(acc + 1));
    check("decr_no_act", 64'(act_cnt[0] - a0 + act_cnt[1] - a1), 64'd0);

`ifdef AXI_LITE_SPLIT_TIMEOUT_EN
    // Port 0 never accepts AR
    rdy_en[0] = 1'b0;
    sb.push_back('{1'b0, 2'b10, 32'h0});
    rd_xact(32'h0000_0020, acc, rsp);
    check("to_fault", 64'(port_fault), 64'b01);
    check("to_valids_low", 64'({m_axi_arvalid, m_axi_rready}), 64'd0);
    a0 = act_cnt[0];
    sb.push_back('{1'b0, 2'b10, 32'h0});
    rd_xact(32'h0000_0024, acc, rsp);
    check("fault_r_lat", 64'(rsp), 64'(acc + 1));
    sb.push_back('{1'b1, 2'b10, 32'h0});
    wr_xact(32'h0000_0028, 32'h1, acc, rsp);
    check("fault_w_lat", 64'(rsp), 64'(acc + 1));
    check("fault_no_act", 64'(act_cnt[0] - a0), 64'd0);
    rdy_en[0] = 1'b1;
`endif

    // Reset while waiting in WR_B
    rsp_en[1] = 1'b0;
    s_axi_awaddr = 32'h0001_0010;
    s_axi_wdata = 32'h0BAD_F00D;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s_axi_awready) begin ok = 1; break; end
    end
    check("rstb_accept", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (m_axi_bready != '0) begin ok = 1; break; end
    end
    check("rstb_in_wr_b", 64'(m_axi_bready), 64'b10);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstb_m_low", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                             m_axi_arvalid, m_axi_rready}), 64'd0);
    check("rstb_s_low", 64'({s_axi_awready, s_axi_arready,
                             s_axi_bvalid, s_axi_rvalid}), 64'd0);
    check("rstb_fault", 64'(port_fault), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rsp_en[1] = 1'b1;

    // Simultaneous write and read, twice after reset: W R W R
    rd_val[1] = 32'hCAFE_F00D;
    for (int r = 0; r < 2; r++) begin
      sb.push_back('{1'b1, 2'b00, 32'h0});
      sb.push_back('{1'b0, 2'b00, 32'hCAFE_F00D});
      fork
        wr_xact(32'h0001_0008, 32'h0000_00A5 + 32'(r), acc, rsp);
        rd_xact(32'h0001_000C, acc2, rsp2);
      join
      check("arb_w_first", 64'(rsp < rsp2), 64'd1);
    end
    check("post_rst_wdata", 64'(last_wdata[1]), 64'h0000_00A6);

    // After a lone write, a collision goes to the read
    sb.push_back('{1'b1, 2'b00, 32'h0});
    wr_xact(32'h0000_0004, 32'h7777_0000, acc, rsp);
    rd_val[0] = 32'h0F0F_0F0F;
    sb.push_back('{1'b0, 2'b00, 32'h0F0F_0F0F});
    sb.push_back('{1'b1, 2'b00, 32'h0});
    fork
      wr_xact(32'h0001_0004, 32'h1111_2222, acc, rsp);
      rd_xact(32'h0000_0008, acc2, rsp2);
    join
    check("arb_r_first", 64'(rsp2 < rsp), 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
